// File: rtl/interconnect_bank_arbiter.sv
// Per-bank request arbiter: picks at most one load or store requester per
// global-memory bank per cycle, round-robin within each request type.
// Stores win by default; a per-bank streak counter forces a load grant once
// STARVE_LIMIT consecutive stores have been granted while a load was waiting.
//
// Request/grant handshake: a PE raises ld_req/st_req with its target bank and
// holds it (request and bank id stable) until it sees the matching gnt in the
// same cycle. A grant is a single-cycle completion. Ungranted requests are not
// latched here. Grants are combinational from requests and the current state.
module interconnect_bank_arbiter #(
  parameter int N_PE               = 4,
  parameter int N_GLOBAL_MEM_BANKS = 4,
  parameter int STARVE_LIMIT       = 4,
  localparam int PW  = $clog2(N_PE),
  localparam int BW  = $clog2(N_GLOBAL_MEM_BANKS),
  localparam int IDW = PW + 1,
  localparam int SW  = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_PE-1:0]                         ld_req,
  input  logic [N_PE-1:0][BW-1:0]                 ld_mem_bank_id,
  input  logic [N_PE-1:0]                         st_req,
  input  logic [N_PE-1:0][BW-1:0]                 st_mem_bank_id,
  input  logic                                    init_mem_vld,
  output logic [N_PE-1:0]                         ld_gnt,
  output logic [N_PE-1:0]                         st_gnt,
  output logic [N_GLOBAL_MEM_BANKS-1:0][IDW-1:0]  granted_requester_id,
  output logic [N_GLOBAL_MEM_BANKS-1:0]           grant_out_port_wise
);

  localparam int NB = N_GLOBAL_MEM_BANKS;

  logic [NB-1:0][PW-1:0] ld_ptr, ld_ptr_nxt;
  logic [NB-1:0][PW-1:0] st_ptr, st_ptr_nxt;
  logic [NB-1:0][SW-1:0] streak, streak_nxt;

  logic [NB-1:0]         ld_hit, st_hit;
  logic [NB-1:0][PW-1:0] ld_sel, st_sel;

  // Round-robin search per bank: first requester at or above the pointer, wrapping.
  always_comb begin
    logic [PW-1:0] idx;
    ld_hit = '0;
    st_hit = '0;
    ld_sel = '0;
    st_sel = '0;
    idx    = '0;
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < N_PE; i++) begin
        idx = ld_ptr[b] + PW'(i);
        if (!ld_hit[b] && ld_req[idx] && (ld_mem_bank_id[idx] == BW'(b))) begin
          ld_hit[b] = 1'b1;
          ld_sel[b] = idx;
        end
        idx = st_ptr[b] + PW'(i);
        if (!st_hit[b] && st_req[idx] && (st_mem_bank_id[idx] == BW'(b))) begin
          st_hit[b] = 1'b1;
          st_sel[b] = idx;
        end
      end
    end
  end

  // Type select per bank, grant outputs and next-state; idle while in reset or init.
  always_comb begin
    ld_gnt              = '0;
    st_gnt              = '0;
    grant_out_port_wise = '0;
    ld_ptr_nxt          = ld_ptr;
    st_ptr_nxt          = st_ptr;
    streak_nxt          = streak;
    for (int b = 0; b < NB; b++) begin
      granted_requester_id[b] = {1'b1, {PW{1'b0}}};
    end
    if (rst && !init_mem_vld) begin
      for (int b = 0; b < NB; b++) begin
        if (st_hit[b] && !(ld_hit[b] && (streak[b] == SW'(STARVE_LIMIT)))) begin
          st_gnt[st_sel[b]]       = 1'b1;
          granted_requester_id[b] = {1'b0, st_sel[b]};
          grant_out_port_wise[b]  = 1'b1;
          st_ptr_nxt[b]           = st_sel[b] + PW'(1);
          if (!ld_hit[b]) begin
            streak_nxt[b] = '0;
          end else if (streak[b] != SW'(STARVE_LIMIT)) begin
            streak_nxt[b] = streak[b] + SW'(1);
          end
        end else if (ld_hit[b]) begin
          ld_gnt[ld_sel[b]]       = 1'b1;
          granted_requester_id[b] = {1'b1, ld_sel[b]};
          grant_out_port_wise[b]  = 1'b1;
          ld_ptr_nxt[b]           = ld_sel[b] + PW'(1);
          streak_nxt[b]           = '0;
        end else begin
          streak_nxt[b] = '0;
        end
      end
    end
  end

  // Per-bank pointer and streak registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_ptr <= '0;
      st_ptr <= '0;
      streak <= '0;
    end else begin
      ld_ptr <= ld_ptr_nxt;
      st_ptr <= st_ptr_nxt;
      streak <= streak_nxt;
    end
  end

endmodule

// File: tb/tb_interconnect_bank_arbiter.sv
// Testbench for interconnect_bank_arbiter (N_PE=4, 4 banks, STARVE_LIMIT=4).
// A reference model predicts every cycle's full output vector into a queue;
// directed scenarios additionally check individual fields against constants.
module tb_interconnect_bank_arbiter;

  localparam int NP  = 4;
  localparam int NB  = 4;
  localparam int LIM = 4;
  localparam int W   = 2 * NP + NB + NB * 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]       ld_req, st_req;
  logic [NP-1:0][1:0]  ld_bank, st_bank;
  logic                init_mem_vld;
  logic [NP-1:0]       ld_gnt, st_gnt;
  logic [NB-1:0][2:0]  gid;
  logic [NB-1:0]       pw;

  interconnect_bank_arbiter #(
    .N_PE(NP), .N_GLOBAL_MEM_BANKS(NB), .STARVE_LIMIT(LIM)
  ) dut (
    .clk                  (clk),
    .rst                  (rst_n),
    .ld_req               (ld_req),
    .ld_mem_bank_id       (ld_bank),
    .st_req               (st_req),
    .st_mem_bank_id       (st_bank),
    .init_mem_vld         (init_mem_vld),
    .ld_gnt               (ld_gnt),
    .st_gnt               (st_gnt),
    .granted_requester_id (gid),
    .grant_out_port_wise  (pw)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // sampled outputs of the most recent step
  logic [NP-1:0]      s_ld, s_st;
  logic [NB-1:0]      s_pw;
  logic [NB-1:0][2:0] s_id;

  // reference model state
  int m_ld_ptr[NB], m_st_ptr[NB], m_streak[NB];
  int n_ld_ptr[NB], n_st_ptr[NB], n_streak[NB];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: winner is the requester at minimum round-robin distance from the pointer.
  task automatic model_eval(output logic [W-1:0] e);
    logic [NP-1:0]      lg, sg;
    logic [NB-1:0]      pg;
    logic [NB-1:0][2:0] id;
    int bl, bs, dl, ds, d;
    lg = '0; sg = '0; pg = '0;
    for (int b = 0; b < NB; b++) begin
      id[b] = 3'b100;
      n_ld_ptr[b] = m_ld_ptr[b];
      n_st_ptr[b] = m_st_ptr[b];
      n_streak[b] = m_streak[b];
    end
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        n_ld_ptr[b] = 0; n_st_ptr[b] = 0; n_streak[b] = 0;
      end
    end else if (!init_mem_vld) begin
      for (int b = 0; b < NB; b++) begin
        bl = -1; bs = -1; dl = NP; ds = NP;
        for (int p = 0; p < NP; p++) begin
          if (ld_req[p] && int'(ld_bank[p]) == b) begin
            d = (p - m_ld_ptr[b] + NP) % NP;
            if (d < dl) begin dl = d; bl = p; end
          end
          if (st_req[p] && int'(st_bank[p]) == b) begin
            d = (p - m_st_ptr[b] + NP) % NP;
            if (d < ds) begin ds = d; bs = p; end
          end
        end
        if (bl >= 0 && (bs < 0 || m_streak[b] == LIM)) begin
          lg[bl] = 1'b1; pg[b] = 1'b1; id[b] = {1'b1, 2'(bl)};
          n_ld_ptr[b] = (bl + 1) % NP;
          n_streak[b] = 0;
        end else if (bs >= 0) begin
          sg[bs] = 1'b1; pg[b] = 1'b1; id[b] = {1'b0, 2'(bs)};
          n_st_ptr[b] = (bs + 1) % NP;
          n_streak[b] = (bl >= 0) ? ((m_streak[b] + 1 > LIM) ? LIM : m_streak[b] + 1) : 0;
        end else begin
          n_streak[b] = 0;
        end
      end
    end
    e = {lg, sg, pg, id};
  endtask

  // One cycle: predict, sample mid-cycle, compare, advance model with the clock.
  task automatic step();
    logic [W-1:0] e, o;
    model_eval(e);
    exp_q.push_back(e);
    @(negedge clk);
    s_ld = ld_gnt; s_st = st_gnt; s_pw = pw; s_id = gid;
    o = {ld_gnt, st_gnt, pw, gid};
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'(o), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check_val("sb", 32'(o), 32'(e));
    end
    @(posedge clk);
    for (int b = 0; b < NB; b++) begin
      m_ld_ptr[b] = n_ld_ptr[b];
      m_st_ptr[b] = n_st_ptr[b];
      m_streak[b] = n_streak[b];
    end
    #1;
  endtask

  task automatic clear_inputs();
    ld_req = '0; st_req = '0; ld_bank = '0; st_bank = '0; init_mem_vld = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_ld"}, 32'(s_ld), 32'h0);
    check_val({tag, "_st"}, 32'(s_st), 32'h0);
    check_val({tag, "_pw"}, 32'(s_pw), 32'h0);
    check_val({tag, "_id"}, 32'(s_id), 32'h924);
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      m_ld_ptr[b] = 0; m_st_ptr[b] = 0; m_streak[b] = 0;
    end
    clear_inputs();
    // reset with requests present: outputs forced idle
    ld_req = 4'b1111; st_req = 4'b0101;
    step();
    check_idle("rst");
    step();
    clear_inputs();
    rst_n = 1'b1;
    step();
    check_idle("post_rst_idle");

    // 1: PE1, PE3 load bank2 round-robin
    ld_req = 4'b1010; ld_bank[1] = 2'd2; ld_bank[3] = 2'd2;
    step();
    check_val("t1_c0_ld", 32'(s_ld), 32'b0010);
    check_val("t1_c0_id", 32'(s_id[2]), 32'b101);
    step();
    check_val("t1_c1_ld", 32'(s_ld), 32'b1000);
    check_val("t1_c1_id", 32'(s_id[2]), 32'b111);
    step();
    check_val("t1_c2_ld", 32'(s_ld), 32'b0010);
    clear_inputs();

    // 2: PE0 store vs PE2 load on bank1, starvation forcing
    st_req[0] = 1'b1; st_bank[0] = 2'd1; ld_req[2] = 1'b1; ld_bank[2] = 2'd1;
    for (int c = 0; c < 4; c++) begin
      step();
      check_val($sformatf("t2_st%0d", c), 32'(s_st), 32'b0001);
      check_val($sformatf("t2_id%0d", c), 32'(s_id[1]), 32'b000);
    end
    step();
    check_val("t2_forced_ld", 32'(s_ld), 32'b0100);
    check_val("t2_forced_id", 32'(s_id[1]), 32'b110);
    step();
    check_val("t2_st_again", 32'(s_st), 32'b0001);

    // 6: reset mid-streak (streak at 3), then full streak again
    step(); step();
    rst_n = 1'b0;
    step();
    check_idle("t6_rst");
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check_val($sformatf("t6_st%0d", c), 32'(s_st), 32'b0001);
    end
    step();
    check_val("t6_forced_ld", 32'(s_ld), 32'b0100);
    clear_inputs();

    // 3: pointer wrap on bank0
    ld_req[2] = 1'b1; ld_bank[2] = 2'd0;
    step();
    clear_inputs();
    ld_req = 4'b1001; ld_bank[0] = 2'd0; ld_bank[3] = 2'd0;
    step();
    check_val("t3_pe3", 32'(s_ld), 32'b1000);
    step();
    check_val("t3_pe0", 32'(s_ld), 32'b0001);
    clear_inputs();

    // 4: all PEs to distinct banks
    ld_req = 4'b1111;
    ld_bank[0] = 2'd3; ld_bank[1] = 2'd2; ld_bank[2] = 2'd1; ld_bank[3] = 2'd0;
    step();
    check_val("t4_ld", 32'(s_ld), 32'b1111);
    check_val("t4_pw", 32'(s_pw), 32'b1111);
    clear_inputs();

    // 5: init port owns banks; pointers hold across it
    ld_req = 4'b1010; ld_bank[1] = 2'd2; ld_bank[3] = 2'd2;
    st_req = 4'b0001; st_bank[0] = 2'd3;
    init_mem_vld = 1'b1;
    step();
    check_idle("t5_init");
    step();
    init_mem_vld = 1'b0;
    st_req = '0;
    step();
    check_val("t5_resume_pe3", 32'(s_ld), 32'b1000);
    step();
    check_val("t5_resume_pe1", 32'(s_ld), 32'b0010);
    clear_inputs();

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      ld_req = 4'($urandom_range(0, 15));
      st_req = 4'($urandom_range(0, 15));
      for (int p = 0; p < NP; p++) begin
        ld_bank[p] = 2'($urandom_range(0, 3));
        st_bank[p] = 2'($urandom_range(0, 3));
      end
      init_mem_vld = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1'b1;
    clear_inputs();
    step();

    check_val("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
